// File: rtl/alu_port_arbiter.sv
// Shares one ALU operand path between the execute issue (port 0) and the multi-cycle
// unit (port 1): round-robin issue onto registered ALU inputs, tagged result return.
module alu_port_arbiter #(
    parameter int DW      = 32,
    parameter int OPW     = 4,
    parameter int ALU_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0,
    input  logic [DW-1:0]  op_a0,
    input  logic [DW-1:0]  op_b0,
    input  logic [OPW-1:0] opc0,
    output logic           ack0,
    output logic           rsp_valid0,
    input  logic           flush0,
    input  logic           req1,
    input  logic [DW-1:0]  op_a1,
    input  logic [DW-1:0]  op_b1,
    input  logic [OPW-1:0] opc1,
    output logic           ack1,
    output logic           rsp_valid1,
    output logic [DW-1:0]  rsp_data,
    output logic           alu_valid,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_op,
    output logic           mux_sel,
    input  logic [DW-1:0]  alu_result
);

    // Handshake: reqN is a level held with stable operands/opcode until ackN is seen;
    // ackN is a registered one-cycle pulse, and reqN is not sampled while ackN is high.
    logic           elig0;
    logic           elig1;
    logic           any_elig;
    logic           win;

    logic           ack0_q, ack0_d;
    logic           ack1_q, ack1_d;
    logic           alu_valid_q, alu_valid_d;
    logic           mux_sel_q, mux_sel_d;
    logic           last_grant_q, last_grant_d;
    logic           issue_live_q, issue_live_d;
    logic [DW-1:0]  alu_a_q, alu_a_d;
    logic [DW-1:0]  alu_b_q, alu_b_d;
    logic [OPW-1:0] alu_op_q, alu_op_d;
    logic           rsp_valid0_q, rsp_valid0_d;
    logic           rsp_valid1_q, rsp_valid1_d;
    logic [DW-1:0]  rsp_data_q, rsp_data_d;

    // Per-stage {valid, owner} as seen this cycle, already masked by flush0.
    logic [ALU_LAT:0] stg_v;
    logic [ALU_LAT:0] stg_o;

    assign elig0    = req0 & ~ack0_q;
    assign elig1    = req1 & ~ack1_q;
    assign any_elig = elig0 | elig1;
    assign win      = elig1 & (~elig0 | ~last_grant_q);

    always_comb begin
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        alu_valid_d  = any_elig;
        mux_sel_d    = mux_sel_q;
        last_grant_d = last_grant_q;
        issue_live_d = 1'b0;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        if (any_elig) begin
            ack0_d       = ~win;
            ack1_d       = win;
            mux_sel_d    = win;
            last_grant_d = win;
            // A port-0 issue that coincides with flush0 still goes out but never answers.
            issue_live_d = ~(flush0 & ~win);
            alu_a_d      = win ? op_a1 : op_a0;
            alu_b_d      = win ? op_b1 : op_b0;
            alu_op_d     = win ? opc1 : opc0;
        end
    end

    assign stg_v[0] = alu_valid_q & issue_live_q & ~(flush0 & ~mux_sel_q);
    assign stg_o[0] = mux_sel_q;

    generate
        if (ALU_LAT > 0) begin : g_tag_pipe
            logic [ALU_LAT-1:0] tag_v_q;
            logic [ALU_LAT-1:0] tag_o_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tag_v_q <= '0;
                    tag_o_q <= '0;
                end else begin
                    tag_v_q <= stg_v[ALU_LAT-1:0];
                    tag_o_q <= stg_o[ALU_LAT-1:0];
                end
            end

            assign stg_v[ALU_LAT:1] = tag_v_q & ~({ALU_LAT{flush0}} & ~tag_o_q);
            assign stg_o[ALU_LAT:1] = tag_o_q;
        end
    endgenerate

    // The last stage lines up with alu_result being valid, so capture it here.
    always_comb begin
        rsp_valid0_d = stg_v[ALU_LAT] & ~stg_o[ALU_LAT];
        rsp_valid1_d = stg_v[ALU_LAT] & stg_o[ALU_LAT];
        rsp_data_d   = stg_v[ALU_LAT] ? alu_result : rsp_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            alu_valid_q  <= 1'b0;
            mux_sel_q    <= 1'b0;
            last_grant_q <= 1'b1;
            issue_live_q <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            alu_valid_q  <= alu_valid_d;
            mux_sel_q    <= mux_sel_d;
            last_grant_q <= last_grant_d;
            issue_live_q <= issue_live_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_valid0_q <= rsp_valid0_d;
            rsp_valid1_q <= rsp_valid1_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign alu_valid  = alu_valid_q;
    assign mux_sel    = mux_sel_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid0 = rsp_valid0_q;
    assign rsp_valid1 = rsp_valid1_q;
    assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_alu_port_arbiter.sv
// Bench for alu_port_arbiter: three builds (ALU_LAT 1, 0, 3) share stimulus and are
// checked against a transaction-level reference model plus directed timing checks.
module tb_alu_port_arbiter;

    localparam int DW  = 32;
    localparam int OPW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic           req0, req1, flush0;
    logic [DW-1:0]  op_a0, op_b0, op_a1, op_b1;
    logic [OPW-1:0] opc0, opc1;

    logic           ack0_w [3];
    logic           ack1_w [3];
    logic           rv0_w  [3];
    logic           rv1_w  [3];
    logic           av_w   [3];
    logic           sel_w  [3];
    logic [DW-1:0]  rdata_w [3];
    logic [DW-1:0]  a_w    [3];
    logic [DW-1:0]  b_w    [3];
    logic [DW-1:0]  res_w  [3];
    logic [OPW-1:0] op_w   [3];

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [OPW-1:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    endfunction

    // ---------------- DUTs and bench ALUs ----------------
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

        alu_port_arbiter #(.DW(DW), .OPW(OPW), .ALU_LAT(L)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req0       (req0),
            .op_a0      (op_a0),
            .op_b0      (op_b0),
            .opc0       (opc0),
            .ack0       (ack0_w[g]),
            .rsp_valid0 (rv0_w[g]),
            .flush0     (flush0),
            .req1       (req1),
            .op_a1      (op_a1),
            .op_b1      (op_b1),
            .opc1       (opc1),
            .ack1       (ack1_w[g]),
            .rsp_valid1 (rv1_w[g]),
            .rsp_data   (rdata_w[g]),
            .alu_valid  (av_w[g]),
            .alu_a      (a_w[g]),
            .alu_b      (b_w[g]),
            .alu_op     (op_w[g]),
            .mux_sel    (sel_w[g]),
            .alu_result (res_w[g])
        );

        if (L == 0) begin : g_comb_alu
            assign res_w[g] = alu_f(a_w[g], b_w[g], op_w[g]);
        end else begin : g_seq_alu
            logic [DW-1:0] sh [L];
            always @(posedge clk) begin
                sh[0] <= alu_f(a_w[g], b_w[g], op_w[g]);
                for (int k = 1; k < L; k++) sh[k] <= sh[k-1];
            end
            assign res_w[g] = sh[L-1];
        end
    end

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        int            issue;
        bit            owner;
        logic [DW-1:0] data;
        logic [2:0]    live;
    } ent_t;

    ent_t           pend [$];
    int             cyc;
    bit             m_last;
    logic           m_ack0, m_ack1, m_av, m_sel;
    logic [DW-1:0]  m_a, m_b;
    logic [OPW-1:0] m_op;
    logic           m_rv0 [3];
    logic           m_rv1 [3];
    logic [DW-1:0]  m_rd  [3];

    always @(posedge clk or negedge rst_n) begin : ref_model
        ent_t e;
        bit   e0, e1, w;
        if (!rst_n) begin
            m_last = 1'b1;
            m_ack0 = 1'b0; m_ack1 = 1'b0; m_av = 1'b0; m_sel = 1'b0;
            m_a = '0; m_b = '0; m_op = '0;
            pend.delete();
            cyc = 0;
            for (int g = 0; g < 3; g++) begin
                m_rv0[g] = 1'b0; m_rv1[g] = 1'b0; m_rd[g] = '0;
            end
        end else begin
            // flush in this cycle kills every port-0 result not yet returned
            if (flush0) begin
                for (int i = 0; i < pend.size(); i++) begin
                    e = pend[i];
                    for (int g = 0; g < 3; g++)
                        if (!e.owner && (e.issue + lat_of(g) + 1 > cyc)) e.live[g] = 1'b0;
                    pend[i] = e;
                end
            end
            e0 = req0 && !m_ack0;
            e1 = req1 && !m_ack1;
            w  = (e0 && e1) ? !m_last : e1;
            if (e0 || e1) begin
                m_last = w;
                m_ack0 = !w; m_ack1 = w; m_av = 1'b1; m_sel = w;
                m_a  = w ? op_a1 : op_a0;
                m_b  = w ? op_b1 : op_b0;
                m_op = w ? opc1 : opc0;
                e.issue = cyc + 1;
                e.owner = w;
                e.data  = alu_f(m_a, m_b, m_op);
                e.live  = (flush0 && !w) ? 3'b000 : 3'b111;
                pend.push_back(e);
            end else begin
                m_ack0 = 1'b0; m_ack1 = 1'b0; m_av = 1'b0;
            end
            cyc++;
            for (int g = 0; g < 3; g++) begin
                m_rv0[g] = 1'b0; m_rv1[g] = 1'b0;
                for (int i = 0; i < pend.size(); i++) begin
                    if (pend[i].issue + lat_of(g) + 1 == cyc && pend[i].live[g]) begin
                        if (pend[i].owner) m_rv1[g] = 1'b1;
                        else               m_rv0[g] = 1'b1;
                        m_rd[g] = pend[i].data;
                    end
                end
            end
            while (pend.size() > 0 && pend[0].issue + 4 < cyc) void'(pend.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // A requester with an un-acked request keeps holding it; otherwise it starts anew.
    task automatic drive(input bit w0, input bit w1, input bit fl);
        if (!(req0 && !m_ack0)) begin
            req0 = w0; op_a0 = $urandom; op_b0 = $urandom; opc0 = OPW'($urandom_range(0, 5));
        end
        if (!(req1 && !m_ack1)) begin
            req1 = w1; op_a1 = $urandom; op_b1 = $urandom; opc1 = OPW'($urandom_range(0, 5));
        end
        flush0 = fl;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            n_vec++;
            if ({ack0_w[g], ack1_w[g], rv0_w[g], rv1_w[g], av_w[g], sel_w[g]} !== 6'b0) begin
                n_err++;
                $display("FAIL reset_ctrl lat%0d: got %b%b%b%b%b%b want 000000", lat_of(g),
                         ack0_w[g], ack1_w[g], rv0_w[g], rv1_w[g], av_w[g], sel_w[g]);
            end
            n_vec++;
            if ({rdata_w[g], a_w[g], b_w[g], op_w[g]} !== '0) begin
                n_err++;
                $display("FAIL reset_data lat%0d: got %h %h %h %h want all 0", lat_of(g),
                         rdata_w[g], a_w[g], b_w[g], op_w[g]);
            end
        end
        rst_n = 1'b1;
        tick();
        for (int g = 0; g < 3; g++) begin
            n_vec++;
            if ({ack0_w[g], ack1_w[g], rv0_w[g], rv1_w[g], av_w[g]} !== 5'b0) begin
                n_err++;
                $display("FAIL idle_after_reset lat%0d: got %b%b%b%b%b want 00000", lat_of(g),
                         ack0_w[g], ack1_w[g], rv0_w[g], rv1_w[g], av_w[g]);
            end
        end
    endtask

    task automatic test_issue_latency;
        req0 = 1'b1; op_a0 = 32'd5; op_b0 = 32'd7; opc0 = 4'd0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            for (int g = 0; g < 3; g++) begin
                n_vec++;
                if ({ack0_w[g], av_w[g], ack1_w[g]} !== {(k == 1), (k == 1), 1'b0}) begin
                    n_err++;
                    $display("FAIL single_issue lat%0d k%0d: got ack0/av/ack1 %b%b%b want %b%b0",
                             lat_of(g), k, ack0_w[g], av_w[g], ack1_w[g], (k == 1), (k == 1));
                end
                if (k == 1) begin
                    n_vec++;
                    if ({sel_w[g], a_w[g], b_w[g], op_w[g]} !== {1'b0, 32'd5, 32'd7, 4'd0}) begin
                        n_err++;
                        $display("FAIL single_operands lat%0d: got sel %b a %h b %h op %h want 0 5 7 0",
                                 lat_of(g), sel_w[g], a_w[g], b_w[g], op_w[g]);
                    end
                end
                n_vec++;
                if ({rv0_w[g], rv1_w[g]} !== {(k == 2 + lat_of(g)), 1'b0}) begin
                    n_err++;
                    $display("FAIL single_rsp_time lat%0d k%0d: got rv0/rv1 %b%b want %b0",
                             lat_of(g), k, rv0_w[g], rv1_w[g], (k == 2 + lat_of(g)));
                end
                if (k == 2 + lat_of(g)) begin
                    n_vec++;
                    if (rdata_w[g] !== 32'd12) begin
                        n_err++;
                        $display("FAIL single_rsp_data lat%0d: got %h want 0000000c", lat_of(g), rdata_w[g]);
                    end
                end
            end
            if (k == 1) req0 = 1'b0;
        end
    endtask

    task automatic test_only_r1;
        drive(1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            for (int g = 0; g < 3; g++) begin
                n_vec++;
                if ({ack0_w[g], ack1_w[g], av_w[g], sel_w[g]} !==
                    {1'b0, (k % 2 == 1 && k <= 7), (k % 2 == 1 && k <= 7), 1'b1}) begin
                    n_err++;
                    $display("FAIL only_r1 lat%0d k%0d: got ack0/ack1/av/sel %b%b%b%b", lat_of(g), k,
                             ack0_w[g], ack1_w[g], av_w[g], sel_w[g]);
                end
                n_vec++;
                if ({rv0_w[g], rv1_w[g], rdata_w[g]} !== {m_rv0[g], m_rv1[g], m_rd[g]}) begin
                    n_err++;
                    $display("FAIL only_r1_rsp lat%0d k%0d: got %b%b %h want %b%b %h", lat_of(g), k,
                             rv0_w[g], rv1_w[g], rdata_w[g], m_rv0[g], m_rv1[g], m_rd[g]);
                end
            end
            drive(1'b0, k < 7, 1'b0);
        end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            for (int g = 0; g < 3; g++) begin
                if (k <= 12) begin
                    n_vec++;
                    if (av_w[g] !== 1'b1) begin
                        n_err++;
                        $display("FAIL b2b_every_cycle lat%0d k%0d: got av %b want 1", lat_of(g), k, av_w[g]);
                    end
                end
                n_vec++;
                if ({ack0_w[g], ack1_w[g], av_w[g], sel_w[g], a_w[g], b_w[g], op_w[g]} !==
                    {m_ack0, m_ack1, m_av, m_sel, m_a, m_b, m_op}) begin
                    n_err++;
                    $display("FAIL b2b_issue lat%0d k%0d: got %b%b%b%b %h %h %h want %b%b%b%b %h %h %h",
                             lat_of(g), k, ack0_w[g], ack1_w[g], av_w[g], sel_w[g], a_w[g], b_w[g], op_w[g],
                             m_ack0, m_ack1, m_av, m_sel, m_a, m_b, m_op);
                end
                n_vec++;
                if ({rv0_w[g], rv1_w[g], rdata_w[g]} !== {m_rv0[g], m_rv1[g], m_rd[g]}) begin
                    n_err++;
                    $display("FAIL b2b_rsp lat%0d k%0d: got %b%b %h want %b%b %h", lat_of(g), k,
                             rv0_w[g], rv1_w[g], rdata_w[g], m_rv0[g], m_rv1[g], m_rd[g]);
                end
            end
            drive(k < 12, k < 12, 1'b0);
        end
    endtask

    task automatic test_flush;
        req0 = 1'b1; op_a0 = 32'h0000_AAAA; op_b0 = '0; opc0 = 4'd3;
        for (int k = 1; k <= 8; k++) begin
            tick();
            for (int g = 0; g < 3; g++) begin
                n_vec++;
                if ({ack0_w[g], ack1_w[g]} !== {(k == 1), (k == 2)}) begin
                    n_err++;
                    $display("FAIL flush_acks lat%0d k%0d: got %b%b want %b%b", lat_of(g), k,
                             ack0_w[g], ack1_w[g], (k == 1), (k == 2));
                end
                n_vec++;
                if ({rv0_w[g], rv1_w[g]} !== {(lat_of(g) == 0 && k == 2), (k == 3 + lat_of(g))}) begin
                    n_err++;
                    $display("FAIL flush_rsp lat%0d k%0d: got rv0/rv1 %b%b want %b%b", lat_of(g), k,
                             rv0_w[g], rv1_w[g], (lat_of(g) == 0 && k == 2), (k == 3 + lat_of(g)));
                end
                if (k == 3 + lat_of(g)) begin
                    n_vec++;
                    if (rdata_w[g] !== 32'h0000_5555) begin
                        n_err++;
                        $display("FAIL flush_r1_data lat%0d: got %h want 00005555", lat_of(g), rdata_w[g]);
                    end
                end
            end
            if (k == 1) begin
                req0 = 1'b0;
                req1 = 1'b1; op_a1 = 32'h0000_5555; op_b1 = '0; opc1 = 4'd3;
            end else if (k == 2) begin
                req1 = 1'b0; flush0 = 1'b1;
            end else begin
                flush0 = 1'b0;
            end
        end
    endtask

    task automatic test_async_reset;
        drive(1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            n_vec++;
            if ({ack0_w[g], ack1_w[g], rv0_w[g], rv1_w[g], av_w[g], sel_w[g], rdata_w[g], a_w[g], b_w[g], op_w[g]} !== '0) begin
                n_err++;
                $display("FAIL async_reset_outputs lat%0d: got %b%b%b%b%b%b %h %h %h %h want all 0", lat_of(g),
                         ack0_w[g], ack1_w[g], rv0_w[g], rv1_w[g], av_w[g], sel_w[g], rdata_w[g], a_w[g], b_w[g], op_w[g]);
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            for (int g = 0; g < 3; g++) begin
                n_vec++;
                if ({ack0_w[g], ack1_w[g], rv0_w[g], rv1_w[g], av_w[g]} !== 5'b0) begin
                    n_err++;
                    $display("FAIL post_reset_quiet lat%0d k%0d: got %b%b%b%b%b want 00000", lat_of(g), k,
                             ack0_w[g], ack1_w[g], rv0_w[g], rv1_w[g], av_w[g]);
                end
            end
        end
        drive(1'b1, 1'b1, 1'b0);
        tick();
        for (int g = 0; g < 3; g++) begin
            n_vec++;
            if ({ack0_w[g], ack1_w[g], sel_w[g]} !== 3'b100) begin
                n_err++;
                $display("FAIL first_tie_r0 lat%0d: got ack0/ack1/sel %b%b%b want 100", lat_of(g),
                         ack0_w[g], ack1_w[g], sel_w[g]);
            end
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        for (int k = 1; k <= 308; k++) begin
            if (k <= 300)
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0);
            else
                drive(1'b0, 1'b0, 1'b0);
            tick();
            for (int g = 0; g < 3; g++) begin
                n_vec++;
                if ({ack0_w[g], ack1_w[g], av_w[g], sel_w[g], a_w[g], b_w[g], op_w[g]} !==
                    {m_ack0, m_ack1, m_av, m_sel, m_a, m_b, m_op}) begin
                    n_err++;
                    $display("FAIL rand_issue lat%0d k%0d: got %b%b%b%b %h %h %h want %b%b%b%b %h %h %h",
                             lat_of(g), k, ack0_w[g], ack1_w[g], av_w[g], sel_w[g], a_w[g], b_w[g], op_w[g],
                             m_ack0, m_ack1, m_av, m_sel, m_a, m_b, m_op);
                end
                n_vec++;
                if ({rv0_w[g], rv1_w[g], rdata_w[g]} !== {m_rv0[g], m_rv1[g], m_rd[g]}) begin
                    n_err++;
                    $display("FAIL rand_rsp lat%0d k%0d: got %b%b %h want %b%b %h", lat_of(g), k,
                             rv0_w[g], rv1_w[g], rdata_w[g], m_rv0[g], m_rv1[g], m_rd[g]);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        req0 = 1'b0; req1 = 1'b0; flush0 = 1'b0;
        op_a0 = '0; op_b0 = '0; opc0 = '0;
        op_a1 = '0; op_b1 = '0; opc1 = '0;
        test_reset();
        test_issue_latency();
        test_only_r1();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
